// File: rtl/line_raster_pkg.sv
// Shared types and constants for the Bresenham line rasteriser.
package line_raster_pkg;

    // Job sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default screen coordinate width.
    localparam int COORD_W_DEFAULT = 16;

    // The error accumulator needs two bits over the coordinate width:
    // one for the sign and one because |dx|+|dy| can exceed 2^COORD_W.
    function automatic int err_width(input int coord_w);
        return coord_w + 2;
    endfunction

endpackage

// File: rtl/line_step_core.sv
// One Bresenham step: decides which axes advance from the current error
// term and produces the updated error and coordinate.
module line_step_core
    import line_raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int ERR_W   = err_width(COORD_W)
) (
    input  logic signed [ERR_W-1:0]   err,
    input  logic signed [ERR_W-1:0]   dx,
    input  logic signed [ERR_W-1:0]   dy,
    input  logic        [COORD_W-1:0] cur_x,
    input  logic        [COORD_W-1:0] cur_y,
    input  logic                      sx_neg,
    input  logic                      sy_neg,
    output logic signed [ERR_W-1:0]   next_err,
    output logic        [COORD_W-1:0] next_x,
    output logic        [COORD_W-1:0] next_y
);

    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    // e2 is carried one bit wider so doubling the error can never wrap
    logic signed [ERR_W:0] e2;
    logic signed [ERR_W:0] dx_w;
    logic signed [ERR_W:0] dy_w;
    logic                  step_x;
    logic                  step_y;

    // Both axis decisions use the error value from before this step
    always_comb begin
        e2       = {err, 1'b0};
        dx_w     = {dx[ERR_W-1], dx};
        dy_w     = {dy[ERR_W-1], dy};
        step_x   = (e2 >= dy_w);
        step_y   = (e2 <= dx_w);
        next_err = err;
        next_x   = cur_x;
        next_y   = cur_y;
        if (step_x) begin
            next_err = next_err + dy;
            next_x   = sx_neg ? (cur_x - ONE) : (cur_x + ONE);
        end
        if (step_y) begin
            next_err = next_err + dx;
            next_y   = sy_neg ? (cur_y - ONE) : (cur_y + ONE);
        end
    end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: takes one endpoint pair per job and streams
// every pixel of the line over a valid/ready interface, one per clock.
module line_raster
    import line_raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int ERR_W   = err_width(COORD_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               done
);

    state_t state;

    logic        [COORD_W-1:0] x1_r;
    logic        [COORD_W-1:0] y1_r;
    logic        [COORD_W-1:0] x2_r;
    logic        [COORD_W-1:0] y2_r;
    logic signed [ERR_W-1:0]   dx_r;
    logic signed [ERR_W-1:0]   dy_r;
    logic signed [ERR_W-1:0]   err_r;
    logic                      sx_neg_r;
    logic                      sy_neg_r;

    logic        [COORD_W:0]   adx;
    logic        [COORD_W:0]   ady;
    logic signed [ERR_W-1:0]   dx_s;
    logic signed [ERR_W-1:0]   dy_s;

    logic signed [ERR_W-1:0]   next_err;
    logic        [COORD_W-1:0] next_x;
    logic        [COORD_W-1:0] next_y;
    logic                      handshake;

    // Setup arithmetic: absolute deltas in COORD_W+1 bits, then zero-extend
    always_comb begin
        adx  = (x2_r >= x1_r) ? ({1'b0, x2_r} - {1'b0, x1_r})
                              : ({1'b0, x1_r} - {1'b0, x2_r});
        ady  = (y2_r >= y1_r) ? ({1'b0, y2_r} - {1'b0, y1_r})
                              : ({1'b0, y1_r} - {1'b0, y2_r});
        dx_s = $signed({{(ERR_W-COORD_W-1){1'b0}}, adx});
        dy_s = -$signed({{(ERR_W-COORD_W-1){1'b0}}, ady});
    end

    assign handshake = pix_valid && pix_ready;

    line_step_core #(
        .COORD_W (COORD_W),
        .ERR_W   (ERR_W)
    ) u_step (
        .err      (err_r),
        .dx       (dx_r),
        .dy       (dy_r),
        .cur_x    (pix_x),
        .cur_y    (pix_y),
        .sx_neg   (sx_neg_r),
        .sy_neg   (sy_neg_r),
        .next_err (next_err),
        .next_x   (next_x),
        .next_y   (next_y)
    );

    // Job FSM; the pixel outputs double as the current Bresenham position
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            done      <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            x1_r      <= '0;
            y1_r      <= '0;
            x2_r      <= '0;
            y2_r      <= '0;
            dx_r      <= '0;
            dy_r      <= '0;
            err_r     <= '0;
            sx_neg_r  <= 1'b0;
            sy_neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x1_r  <= x1;
                        y1_r  <= y1;
                        x2_r  <= x2;
                        y2_r  <= y2;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dx_r      <= dx_s;
                    dy_r      <= dy_s;
                    err_r     <= dx_s + dy_s;
                    sx_neg_r  <= (x2_r < x1_r);
                    sy_neg_r  <= (y2_r < y1_r);
                    pix_x     <= x1_r;
                    pix_y     <= y1_r;
                    pix_last  <= (x1_r == x2_r) && (y1_r == y2_r);
                    pix_valid <= 1'b1;
                    state     <= STEP;
                end
                STEP: begin
                    if (handshake) begin
                        if (pix_last) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            err_r    <= next_err;
                            pix_x    <= next_x;
                            pix_y    <= next_y;
                            pix_last <= (next_x == x2_r) && (next_y == y2_r);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Scoreboard bench for line_raster: a reference rasteriser fills an expected
// pixel queue per job, a monitor pops and compares on each handshake.
module tb_line_raster;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] x1 = '0;
    logic [CW-1:0] y1 = '0;
    logic [CW-1:0] x2 = '0;
    logic [CW-1:0] y2 = '0;
    logic          busy;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          pix_last;
    logic          done;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          last;
    } pix_t;

    pix_t          exp_q[$];
    int            vec_cnt = 0;
    int            err_cnt = 0;
    int            job_pix = 0;
    int            busy_cyc = 0;
    int            last_x = 0;
    int            last_y = 0;
    bit            ready_mode = 1'b0;

    line_raster #(.COORD_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        vec_cnt++;
        if (act != req) begin
            err_cnt++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference Bresenham; pushes at most maxn pixels
    task automatic push_line(input int ax1, input int ay1, input int ax2, input int ay2,
                             input int maxn);
        int dx, dy, sx, sy, err, e2, x, y;
        pix_t p;
        dx  = (ax2 >= ax1) ? ax2 - ax1 : ax1 - ax2;
        dy  = (ay2 >= ay1) ? ay1 - ay2 : ay2 - ay1;
        sx  = (ax2 >= ax1) ? 1 : -1;
        sy  = (ay2 >= ay1) ? 1 : -1;
        err = dx + dy;
        x   = ax1;
        y   = ay1;
        for (int i = 0; i < maxn; i++) begin
            p.x    = CW'(x);
            p.y    = CW'(y);
            p.last = (x == ax2) && (y == ay2);
            exp_q.push_back(p);
            if (p.last) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Downstream ready: always 1, or the repeating 1,0,0,1 pattern
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                pix_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    // Monitor: handshake compare, done timing, stall stability
    initial begin
        bit   prev_stall;
        bit   prev_last_hs;
        pix_t prev_pix;
        pix_t e;
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
        prev_pix     = '0;
        forever begin
            @(negedge clk);
            if (prev_last_hs) chk("done_after_last", done, 1);
            else if (done) chk("done_spurious", done, 0);
            if (done) chk("done_with_valid", pix_valid, 0);
            if (prev_stall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_x", pix_x, prev_pix.x);
                chk("stall_y", pix_y, prev_pix.y);
                chk("stall_last", pix_last, prev_pix.last);
            end
            if (busy) busy_cyc++;
            if (pix_valid && pix_ready) begin
                job_pix++;
                last_x = pix_x;
                last_y = pix_y;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_x", pix_x, e.x);
                    chk("pix_y", pix_y, e.y);
                    chk("pix_last", pix_last, e.last);
                end
            end
            prev_stall   = pix_valid && !pix_ready && !rst;
            prev_last_hs = pix_valid && pix_ready && pix_last && !rst;
            prev_pix     = {pix_x, pix_y, pix_last};
        end
    end

    task automatic issue_start(input int ax1, input int ay1, input int ax2, input int ay2);
        @(posedge clk);
        #1;
        chk("idle_before_start", busy, 0);
        job_pix  = 0;
        busy_cyc = 0;
        x1 = CW'(ax1); y1 = CW'(ay1); x2 = CW'(ax2); y2 = CW'(ay2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("no_valid_in_setup", pix_valid, 0);
        @(posedge clk);
        #1;
        chk("first_valid_latency", pix_valid, 1);
        chk("first_x", pix_x, ax1);
        chk("first_y", pix_y, ay1);
    endtask

    task automatic run_job(input int ax1, input int ay1, input int ax2, input int ay2,
                           input int exp_n, input int exp_busy, input bit inject);
        push_line(ax1, ay1, ax2, ay2, 100000);
        issue_start(ax1, ay1, ax2, ay2);
        if (inject) begin
            repeat (10) @(posedge clk);
            #1;
            x1 = 8'd9; y1 = 8'd9; x2 = 8'd9; y2 = 8'd9;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("busy_during_inject", busy, 1);
        end
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", done, 1);
        @(posedge clk);
        #1;
        chk("busy_low_after_done", busy, 0);
        chk("pixel_count", job_pix, exp_n);
        chk("final_x", last_x, ax2);
        chk("final_y", last_y, ay2);
        chk("queue_drained", exp_q.size(), 0);
        if (exp_busy >= 0) chk("busy_cycles", busy_cyc, exp_busy);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_done", done, 0);
        chk("rst_x", pix_x, 0);
        chk("rst_y", pix_y, 0);
        rst = 1'b0;

        // Diagonal, +X +Y
        run_job(10, 20, 30, 40, 21, 23, 1'b0);
        // Degenerate point: busy covers SETUP, STEP, DONE
        run_job(5, 5, 5, 5, 1, 3, 1'b0);
        // Shallow, -X +Y
        run_job(30, 2, 0, 10, 31, 33, 1'b0);
        // Steep with back-pressure
        ready_mode = 1'b1;
        run_job(0, 0, 3, 12, 13, -1, 1'b0);
        run_job(7, 0, 7, 9, 10, -1, 1'b0);
        ready_mode = 1'b0;
        @(posedge clk);
        #1;
        // Horizontal, -X
        run_job(40, 7, 0, 7, 41, 43, 1'b0);

        // Reset during the 4th pixel of a horizontal line
        push_line(0, 0, 20, 0, 4);
        issue_start(0, 0, 20, 0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 8'd3) break;
        end
        chk("reached_4th_pixel", pix_x, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", pix_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_x", pix_x, 0);
        chk("midrst_last", pix_last, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_more", pix_valid, 0);
        chk("midrst_queue", exp_q.size(), 0);
        run_job(1, 1, 2, 2, 2, 4, 1'b0);

        // start together with rst: reset wins
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        x1 = 8'd1; y1 = 8'd2; x2 = 8'd3; y2 = 8'd4;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        chk("rst_wins_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("rst_wins_idle", busy, 0);
        chk("rst_wins_valid", pix_valid, 0);

        // Full-width lines, start pulse while busy is ignored
        run_job(0, 0, 255, 3, 256, 258, 1'b1);
        run_job(0, 255, 255, 0, 256, 258, 1'b0);
        run_job(3, 250, 0, 0, 251, 253, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        err_cnt++;
        $display("FAIL global_timeout: actual %0t, required completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
